// File: rtl/dpu.sv
// dpu: 16x8 register-file datapath with registered condition codes and a toggle-requested pixel word.
// Optional DPU_SAT_EN: add/sub results saturate to the signed limits on overflow.
module dpu #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     a_sel,
  input  logic [3:0]     b_sel,
  input  logic [3:0]     r_sel,
  input  logic [3:0]     n,
  input  logic [W-1:0]   m_data,
  input  logic           out_enable,
  output logic [3:0]     cc,
  output logic [3*W-1:0] kbus,
  output logic           kbus_valid
);

  localparam int unsigned NREG = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SAR = 4'd3;
  localparam logic [3:0] OP_MVA = 4'd4;
  localparam logic [3:0] OP_MVB = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd8;

  localparam logic [3:0] R_X    = 4'd9;
  localparam logic [3:0] R_Y    = 4'd10;
  localparam logic [3:0] R_COL  = 4'd11;
  localparam logic [3:0] R_ONE  = 4'd12;
  localparam logic [3:0] R_ZERO = 4'd13;

  logic [W-1:0]   regs_q [NREG];
  logic           oe_q;

  logic [W-1:0]   op_a_c, op_b_c, res_c;
  logic [W:0]     sum_c, diff_c;
  logic           c_c, v_c, wr_en_c, cc_en_c, wr_c, req_c;
  logic [W-1:0]   x_c, y_c, col_c;
  logic [3:0]     cc_d;
  logic [3*W-1:0] kbus_d;
  logic           kbus_valid_d;

  // ALU: operands read combinationally from the register file
  always_comb begin
    op_a_c  = regs_q[a_sel];
    op_b_c  = regs_q[b_sel];
    sum_c   = {1'b0, op_a_c} + {1'b0, op_b_c};
    diff_c  = {1'b0, op_a_c} - {1'b0, op_b_c};
    res_c   = '0;
    c_c     = 1'b0;
    v_c     = 1'b0;
    wr_en_c = 1'b0;
    cc_en_c = 1'b0;
    case (n)
      OP_ADD: begin
        res_c   = sum_c[W-1:0];
        c_c     = sum_c[W];
        v_c     = (op_a_c[W-1] == op_b_c[W-1]) && (sum_c[W-1] != op_a_c[W-1]);
        wr_en_c = 1'b1;
        cc_en_c = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res_c   = diff_c[W-1:0];
        c_c     = diff_c[W];
        v_c     = (op_a_c[W-1] != op_b_c[W-1]) && (diff_c[W-1] != op_a_c[W-1]);
        wr_en_c = (n == OP_SUB);
        cc_en_c = 1'b1;
      end
      OP_SHL: begin
        res_c   = {op_a_c[W-2:0], 1'b0};
        c_c     = op_a_c[W-1];
        wr_en_c = 1'b1;
        cc_en_c = 1'b1;
      end
      OP_SAR: begin
        res_c   = {op_a_c[W-1], op_a_c[W-1:1]};
        c_c     = op_a_c[0];
        wr_en_c = 1'b1;
        cc_en_c = 1'b1;
      end
      OP_MVA: begin
        res_c   = op_a_c;
        wr_en_c = 1'b1;
      end
      OP_MVB: begin
        res_c   = op_b_c;
        wr_en_c = 1'b1;
      end
      OP_LDI: begin
        res_c   = m_data;
        wr_en_c = 1'b1;
      end
      default: ;
    endcase
`ifdef DPU_SAT_EN
    // Overflow direction follows the sign of A for both add and subtract
    if (((n == OP_ADD) || (n == OP_SUB)) && v_c) begin
      res_c = op_a_c[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
`endif
  end

  // Writeback, flag update and pixel request with forwarding of same-edge writes
  always_comb begin
    wr_c         = wr_en_c && (r_sel != R_ONE) && (r_sel != R_ZERO);
    cc_d         = cc_en_c ? {res_c[W-1], (res_c == '0), c_c, v_c} : cc;
    x_c          = (wr_c && (r_sel == R_X))   ? res_c : regs_q[R_X];
    y_c          = (wr_c && (r_sel == R_Y))   ? res_c : regs_q[R_Y];
    col_c        = (wr_c && (r_sel == R_COL)) ? res_c : regs_q[R_COL];
    req_c        = (out_enable != oe_q);
    kbus_d       = req_c ? {x_c, y_c, col_c} : kbus;
    kbus_valid_d = req_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      regs_q[R_ONE] <= W'(1);
      cc            <= '0;
      kbus          <= '0;
      kbus_valid    <= 1'b0;
      oe_q          <= out_enable;
    end else begin
      if (wr_c) begin
        regs_q[r_sel] <= res_c;
      end
      cc         <= cc_d;
      kbus       <= kbus_d;
      kbus_valid <= kbus_valid_d;
      oe_q       <= out_enable;
    end
  end

endmodule

// File: tb/tb_dpu.sv
// tb_dpu: directed scenarios plus random micro-op streams checked against an integer-arithmetic model.
module tb_dpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a_sel, b_sel, r_sel, n;
  logic [7:0]  m_data;
  logic        out_enable;
  logic [3:0]  cc;
  logic [23:0] kbus;
  logic        kbus_valid;

  dpu #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .r_sel      (r_sel),
    .n          (n),
    .m_data     (m_data),
    .out_enable (out_enable),
    .cc         (cc),
    .kbus       (kbus),
    .kbus_valid (kbus_valid)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_regs [16];
  int   m_cc;
  int   m_kbus;
  int   m_kv;
  logic m_oe;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_s(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  // Reference: plain integer arithmetic on the architectural state
  task automatic model_step();
    int ua, ub, sa, sb, s, res, c, v;
    bit wr, upd;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_regs[12] = 1;
      m_cc = 0; m_kbus = 0; m_kv = 0;
      m_oe = out_enable;
      return;
    end
    ua = m_regs[a_sel]; ub = m_regs[b_sel];
    sa = to_s(ua);      sb = to_s(ub);
    res = 0; c = 0; v = 0; s = 0; wr = 0; upd = 0;
    case (int'(n))
      0: begin
        s = sa + sb; res = (ua + ub) % 256;
        c = (ua + ub > 255) ? 1 : 0;
        v = (s > 127 || s < -128) ? 1 : 0;
        wr = 1; upd = 1;
      end
      1, 6: begin
        s = sa - sb; res = (ua - ub + 256) % 256;
        c = (ua < ub) ? 1 : 0;
        v = (s > 127 || s < -128) ? 1 : 0;
        wr = (n == 4'd1); upd = 1;
      end
      2: begin res = (ua * 2) % 256; c = ua / 128; wr = 1; upd = 1; end
      3: begin res = (sa >>> 1) & 255; c = ua % 2; wr = 1; upd = 1; end
      4: begin res = ua; wr = 1; end
      5: begin res = ub; wr = 1; end
      8: begin res = int'(m_data); wr = 1; end
      default: ;
    endcase
`ifdef DPU_SAT_EN
    if ((n == 4'd0 || n == 4'd1) && v == 1) res = (s > 127) ? 127 : 128;
`endif
    if (upd) m_cc = ((res >= 128) ? 8 : 0) + ((res == 0) ? 4 : 0) + c * 2 + v;
    if (wr && r_sel != 4'd12 && r_sel != 4'd13) m_regs[r_sel] = res;
    if (out_enable != m_oe) begin
      m_kbus = m_regs[9] * 65536 + m_regs[10] * 256 + m_regs[11];
      m_kv = 1;
    end else begin
      m_kv = 0;
    end
    m_oe = out_enable;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("cc", 32'(cc), 32'(m_cc));
    check_eq("kbus", 32'(kbus), 32'(m_kbus));
    check_eq("kbus_valid", 32'(kbus_valid), 32'(m_kv));
  endtask

  task automatic op(input logic [3:0] op_n, input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] r, input logic [7:0] m, input bit tog);
    n = op_n; a_sel = a; b_sel = b; r_sel = r; m_data = m;
    if (tog) out_enable = ~out_enable;
    cycle();
  endtask

  // Copies a register into the colour slot and requests a pixel to expose it
  task automatic read_reg(input logic [3:0] idx, output logic [7:0] val);
    op(4'd4, idx, 4'd0, 4'd11, 8'd0, 1'b1);
    val = kbus[7:0];
  endtask

  logic [7:0] rv;

  initial begin
    rst = 1'b1; out_enable = 1'b0;
    n = 4'd7; a_sel = '0; b_sel = '0; r_sel = '0; m_data = '0;
    cycle();
    cycle();
    rst = 1'b0;

    op(4'd6, 4'd12, 4'd13, 4'd0, 8'd0, 1'b0);
    check_eq("cmp_1_0_cc", 32'(cc), 32'h0);
    check_eq("reset_kbus", 32'(kbus), 32'h0);
    check_eq("reset_kv", 32'(kbus_valid), 32'h0);
    read_reg(4'd12, rv); check_eq("r12_one", 32'(rv), 32'h1);
    read_reg(4'd13, rv); check_eq("r13_zero", 32'(rv), 32'h0);

    op(4'd8, 4'd0, 4'd0, 4'd9,  8'd10,  1'b0);
    op(4'd8, 4'd0, 4'd0, 4'd10, 8'd20,  1'b0);
    op(4'd8, 4'd0, 4'd0, 4'd11, 8'hAB,  1'b1);
    check_eq("pixel_fwd", 32'(kbus), 32'h000A14AB);
    check_eq("pixel_kv", 32'(kbus_valid), 32'h1);
    op(4'd7, 4'd0, 4'd0, 4'd0, 8'd0, 1'b0);
    check_eq("pixel_kv_drop", 32'(kbus_valid), 32'h0);
    check_eq("pixel_hold", 32'(kbus), 32'h000A14AB);

    op(4'd8, 4'd0, 4'd0, 4'd5, 8'd2, 1'b0);
    op(4'd8, 4'd0, 4'd0, 4'd6, 8'd9, 1'b0);
    op(4'd8, 4'd0, 4'd0, 4'd7, 8'd1, 1'b0);
    op(4'd8, 4'd0, 4'd0, 4'd8, 8'd4, 1'b0);
    op(4'd1, 4'd8, 4'd7, 4'd1, 8'd0, 1'b0);
    op(4'd1, 4'd6, 4'd5, 4'd0, 8'd0, 1'b0);
    op(4'd2, 4'd1, 4'd0, 4'd4, 8'd0, 1'b0);
    op(4'd1, 4'd4, 4'd0, 4'd2, 8'd0, 1'b0);
    op(4'd1, 4'd2, 4'd0, 4'd3, 8'd0, 1'b0);
    read_reg(4'd1, rv); check_eq("r1_dy", 32'(rv), 32'h03);
    read_reg(4'd0, rv); check_eq("r0_dx", 32'(rv), 32'h07);
    read_reg(4'd4, rv); check_eq("r4_shl", 32'(rv), 32'h06);
    read_reg(4'd2, rv); check_eq("r2_err", 32'(rv), 32'hFF);
    read_reg(4'd3, rv); check_eq("r3_einc", 32'(rv), 32'hF8);

    op(4'd6, 4'd2, 4'd13, 4'd0, 8'd0, 1'b0);
    check_eq("cmp_neg_cc", 32'(cc), 32'h8);
    read_reg(4'd0, rv); check_eq("cmp_no_write", 32'(rv), 32'h07);
    op(4'd0, 4'd2, 4'd4, 4'd2, 8'd0, 1'b0);
    check_eq("add_carry_cc", 32'(cc), 32'h2);
    read_reg(4'd2, rv); check_eq("r2_add", 32'(rv), 32'h05);

    op(4'd8, 4'd0, 4'd0, 4'd14, 8'h7F, 1'b0);
    op(4'd0, 4'd14, 4'd12, 4'd15, 8'd0, 1'b0);
`ifdef DPU_SAT_EN
    check_eq("ovf_cc", 32'(cc), 32'h1);
    read_reg(4'd15, rv); check_eq("ovf_res", 32'(rv), 32'h7F);
`else
    check_eq("ovf_cc", 32'(cc), 32'h9);
    read_reg(4'd15, rv); check_eq("ovf_res", 32'(rv), 32'h80);
`endif

    op(4'd8, 4'd0, 4'd0, 4'd12, 8'h55, 1'b0);
    read_reg(4'd12, rv); check_eq("r12_ro", 32'(rv), 32'h1);

    rst = 1'b1;
    op(4'd8, 4'd0, 4'd0, 4'd9, 8'h33, 1'b1);
    check_eq("rst_kbus", 32'(kbus), 32'h0);
    check_eq("rst_kv", 32'(kbus_valid), 32'h0);
    rst = 1'b0;
    op(4'd7, 4'd0, 4'd0, 4'd0, 8'd0, 1'b0);
    check_eq("post_rst_kv", 32'(kbus_valid), 32'h0);
    check_eq("post_rst_kbus", 32'(kbus), 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
         8'($urandom), ($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpu.md
Name: dpu

Overview:
- Datapath unit driven by the command control unit (CCU).
- Holds a 16-entry x 8-bit register file and executes one micro-op per clock, selected by a 4-bit opcode and three 4-bit register selects.
- Produces registered condition codes and a 24-bit pixel word (X, Y, colour) for the frame-buffer side.
- Used for point plotting and Bresenham line drawing.

Parameters:
- W, 8, register and data width in bits. Kbus width is 3*W.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a_sel  in  4  register select for ALU operand A
- b_sel  in  4  register select for ALU operand B
- r_sel  in  4  destination register select
- n  in  4  opcode
- m_data  in  8  immediate data for load
- out_enable  in  1  toggle-style output request; every change of level requests one pixel
- cc  out  4  condition codes {N,Z,C,V} = cc[3:0]
- kbus  out  24  pixel word {R9 (X), R10 (Y), R11 (colour)}, bits 23:16, 15:8, 7:0
- kbus_valid  out  1  one-cycle strobe when kbus is updated

Behaviour:
- Register map:
  - 0 Dx, 1 Dy, 2 Error, 3 EInc, 4 EnoInc, 5 Xs, 6 Xe, 7 Ys, 8 Ye
  - 9 X, 10 Y, 11 Colour
  - 12 constant 1, 13 constant 0 (both read-only; writes ignored)
  - 14 scratch, 15 general.
- Operands A and B are read combinationally. The result is written to R[r_sel] on the rising clock edge. All arithmetic is 8-bit two's complement with wrap-around.
- Opcodes:
  - 0: R = A + B
  - 1: R = A - B
  - 2: R = A << 1 (logical, LSB 0)
  - 3: R = A >>> 1 (arithmetic)
  - 4: R = A
  - 5: R = B
  - 6: compare A - B; updates cc only, no register write
  - 7: no-op
  - 8: R = m_data
  - 9-15: no-op (no write, cc unchanged)
- cc update:
  - Opcodes 0, 1, 2, 3 and 6 update cc at the same edge as the result.
  - N = result[7]; Z = (result == 0).
  - C: carry-out for add; borrow (A < B unsigned) for sub/compare; bit shifted out for shifts.
  - V: signed overflow for add/sub/compare; 0 for shifts.
  - Opcodes 4, 5, 8 and the no-ops leave cc unchanged.
- Latency: a result written at edge k is visible on operand reads after edge k. cc is valid after the executing edge. There is no stall and no handshake.
- Output:
  - The block keeps a registered copy of out_enable.
  - At an edge where out_enable differs from the copy, kbus loads {R9, R10, R11} and kbus_valid goes high for one cycle.
  - If the same edge also writes R9, R10 or R11, kbus carries the newly written value (write-forwarding).
  - A read in the same cycle as a write to that register returns the old value.
  - kbus holds its value between requests.
- Reset (synchronous, rst high at a rising edge):
  - R0-R11, R14 and R15 clear to 0; R12 = 1; R13 = 0.
  - cc = 0, kbus = 0, kbus_valid = 0.
  - The out_enable copy loads the current out_enable, so reset itself never produces a pixel.
  - Reset mid-operation discards that cycle's write and any pending output request.
- Reset has priority over all other actions.

Optional Feature:
- Macro DPU_SAT_EN.
- Defined: opcodes 0 and 1 saturate to +127/-128 on signed overflow. V is still set. The value written is the saturated one, and N/Z reflect it.
- Undefined: wrap-around as specified above.

Test Plan:
- Reset, then a_sel=12, b_sel=13, n=6 -> cc = 4'b0000 (1-0 = 1, no flags); R12 reads 1 and R13 reads 0; kbus = 0, kbus_valid = 0.
- n=8 loads: m_data=10 -> r_sel 9, m_data=20 -> r_sel 10, m_data=0xAB -> r_sel 11; in the same cycle as the R11 write, toggle out_enable -> next cycle kbus = 0x0A14AB, kbus_valid pulses for exactly one cycle.
- Load R5=2, R6=9, R7=1, R8=4; n=1 with (R1 <- R8-R7) and (R0 <- R6-R5); n=2 with R4 <- R1<<1; n=1 with R2 <- R4-R0 and R3 <- R2-R0 -> R1=3, R0=7, R4=6, R2=0xFF (-1), R3=0xF8 (-8).
- n=6 with A=2 (0xFF), B=13 -> cc[3]=1, Z=0, no register written; then n=0 with R2 <- R2+R4 -> R2=5, cc = N0 Z0 C1 V0.
- Overflow: R14 = 0x7F, n=0 with A=14, B=12 -> R = 0x80, V=1, N=1; with DPU_SAT_EN defined -> R = 0x7F, V=1.
- Write R12 with n=8 (m_data=0x55) -> R12 still reads 1; rst asserted together with an out_enable toggle -> kbus stays 0 and no kbus_valid pulse.
